// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter_if
// Description : Bundles the two producer handshakes and the FIFO write port
//               of the two-requester write arbiter.
//               slave  : arbiter side (takes requests, drives readies/write)
//               master : environment side (producers plus FIFO)
// Signals     : s0_valid/s0_data/s0_ready - requester 0 handshake
//               s1_valid/s1_data/s1_ready - requester 1 handshake
//               fifo_afull                - FIFO has <=1 free entry
//               wr_en/wr_data/wr_src      - registered FIFO write port
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_wr_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              s0_valid;
    logic [DATA_W-1:0] s0_data;
    logic              s0_ready;
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic              s1_ready;
    logic              fifo_afull;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              wr_src;

    modport master (
        output s0_valid, s0_data, s1_valid, s1_data, fifo_afull,
        input  s0_ready, s1_ready, wr_en, wr_data, wr_src
    );

    modport slave (
        input  s0_valid, s0_data, s1_valid, s1_data, fifo_afull,
        output s0_ready, s1_ready, wr_en, wr_data, wr_src
    );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Burst-limited round-robin arbiter between two producers and
//               the write port of an 8-bit synchronous FIFO. One word is
//               accepted per cycle; the accepted word is written to the FIFO
//               one cycle later through a registered wr_en/wr_data/wr_src.
//               Both producers are stalled while the FIFO reports almost-full.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous reset, active low
//               bus  - fifo_wr_arbiter_if.slave (requests, readies, write port)
// Parameters  : DATA_W - word width
//               BURST  - max consecutive owner writes while the other waits
//                        (1..15)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int DATA_W = 8,
    parameter int BURST  = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    fifo_wr_arbiter_if.slave  bus
);

    localparam logic [0:0] c_OWN0  = 1'b0;
    localparam logic [0:0] c_OWN1  = 1'b1;
    localparam logic [3:0] c_BURST = 4'(BURST);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_run;
    logic              r_wr_en;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_wr_src;

    logic [0:0]        w_state_nxt;
    logic [3:0]        w_cnt_nxt;
    logic              w_gnt_vld;
    logic [0:0]        w_gnt_idx;
    logic [DATA_W-1:0] w_gnt_data;
    logic              w_s0_ready;
    logic              w_s1_ready;

    // ------------------------------------------------------------------------
    // Owner FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_OWN0;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Cleared asynchronously by reset so both readies drop in the same cycle
    // reset asserts, without routing the reset net into the ready logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Grant selection. A grant always implies the granted requester is valid,
    // so a grant is also a transfer.
    // ------------------------------------------------------------------------
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = r_state;
        if (r_run && !bus.fifo_afull) begin
            if (bus.s0_valid && bus.s1_valid) begin
                w_gnt_vld = 1'b1;
                // Owner keeps the port until its burst budget is used up.
                w_gnt_idx = (r_cnt < c_BURST) ? r_state : ~r_state;
            end else if (bus.s0_valid) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = c_OWN0;
            end else if (bus.s1_valid) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = c_OWN1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Owner FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_run && !bus.fifo_afull) begin
            if (w_gnt_vld) begin
                if (w_gnt_idx == r_state) begin
                    w_cnt_nxt = (r_cnt >= c_BURST) ? c_BURST : r_cnt + 4'd1;
                end else begin
                    w_state_nxt = w_gnt_idx;
                    w_cnt_nxt   = 4'd1;
                end
            end else begin
                // An idle cycle ends the burst; the owner is kept.
                w_cnt_nxt = 4'd0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Owner FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_s0_ready = 1'b0;
        w_s1_ready = 1'b0;
        if (w_gnt_vld) begin
            w_s0_ready = (w_gnt_idx == c_OWN0);
            w_s1_ready = (w_gnt_idx == c_OWN1);
        end
    end

    assign w_gnt_data = (w_gnt_idx == c_OWN1) ? bus.s1_data : bus.s0_data;

    // ------------------------------------------------------------------------
    // Registered FIFO write port
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
            r_wr_src  <= 1'b0;
        end else begin
            r_wr_en <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_wr_data <= w_gnt_data;
                r_wr_src  <= w_gnt_idx;
            end
        end
    end

    assign bus.s0_ready = w_s0_ready;
    assign bus.s1_ready = w_s1_ready;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_data  = r_wr_data;
    assign bus.wr_src   = r_wr_src;

endmodule
`default_nettype wire
